nes_controller_emulator: RTL and testbench
==========================================

# nes_controller_emulator

Responder end of the NES controller serial link: emulates a standard 8-button NES pad on the latch/clock/data wires so that a console, or the team's NES controller reader, can poll board-generated button states. Latch and pulse-clock inputs are synchronized into the 50 MHz system domain and edge-detected. Button levels are captured into a shift register on latch. One button bit per pulse-clock rising edge is presented on the active-low data line, in standard NES order. Intended for loopback verification of the reader and for driving a real console from on-board switches.

## Interface
- SYNC_STAGES, 2, synchronizer depth for latchOrange and clockRed (legal range 2..4)
- clock  in  1  50 MHz system clock; all state updates on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- latchOrange  in  1  latch from the polling side, active-high, asynchronous to clock
- clockRed  in  1  serial pulse clock from the polling side, idle low, asynchronous to clock
- a, b, select, start, up, down, left, right  in  1 each  button levels, 1 = pressed, assumed quasi-static
- dataYellow  out  1  serial data line, 0 = pressed / 1 = released (NES convention)
- bitIndex  out  4  index of the bit currently on dataYellow (0..8)
- frameDone  out  1  one-cycle pulse when the 8th bit has been shifted past

## Operation
- Synchronization:
  - latchOrange and clockRed each pass through SYNC_STAGES flops plus one history flop.
  - latchRise = synchronized latch 0->1; clkRise = synchronized clockRed 0->1.
- Shift register: sr[7:0], bit order A, B, Select, Start, Up, Down, Left, Right (A in sr[0]).
- dataYellow = ~sr[0] in LOAD and SHIFT. dataYellow = 0 in DONE, because a drained pad reads as all-ones to the console. dataYellow = 1 in IDLE.
- IDLE:
  - sr = 0, bitIndex = 0.
  - latchRise -> LOAD.
- LOAD (synchronized latch high):
  - Every cycle, sr <= {right, left, down, up, start, select, b, a} (parallel-load mode tracks buttons, as a 4021 does).
  - bitIndex = 0.
  - clkRise is ignored.
  - Latch falls -> SHIFT, with sr frozen at the last loaded value.
- SHIFT:
  - On clkRise: sr <= {1'b0, sr[7:1]} and bitIndex increments.
  - When bitIndex would become 8: go to DONE and pulse frameDone for one cycle.
- DONE:
  - bitIndex holds at 8.
  - Further clkRise edges have no effect.
- From any state, latchRise restarts: -> LOAD, bitIndex = 0, with no frameDone.
- Latch high overrides the clock: if latchRise and clkRise occur in the same cycle, LOAD wins and the clock edge is discarded.
- Reset mid-frame: asynchronous return to IDLE. Outputs take their reset values immediately; synchronizer flops clear to 0.

## Timing
- Reset values: dataYellow = 1, bitIndex = 0, frameDone = 0, sr = 0, state IDLE.
- Pin-to-output latency is SYNC_STAGES + 1 clock cycles for both latch and clock edges (3 cycles, 60 ns at the default).
- Polling side must hold latchOrange high at least SYNC_STAGES + 2 cycles.
- clockRed high and low phases must each be at least SYNC_STAGES + 1 cycles; shorter pulses may be lost.
- Polling side samples dataYellow before each clockRed rising edge. Bit 0 (A) is valid from latch fall until the first clkRise + latency.
- Button changes during LOAD appear on dataYellow within 1 cycle. Changes during SHIFT/DONE are ignored until the next latch.
- frameDone is asserted in the cycle bitIndex becomes 8.
- No combinational path from any input pin to any output.

## Test plan
- Reset: hold reset_n = 0, toggle pins -> dataYellow = 1, bitIndex = 0, frameDone = 0. Release -> state unchanged until latchRise.
- Full frame with buttons a = 1, start = 1, right = 1, others 0: 12-cycle latch, then 8 clock pulses of 10 cycles high / 10 cycles low. Sampled dataYellow sequence is 0,1,1,0,1,1,1,0; frameDone pulses once after the 8th edge; bitIndex = 8.
- Over-clocking: 4 extra pulses after the frame -> dataYellow stays 0, bitIndex stays 8, no further frameDone.
- Relatch mid-frame: latch after 3 pulses with buttons changed to b = 1 only -> bitIndex = 0, first bit 1, second bit 0, no frameDone for the aborted frame.
- Collision: latch and clockRed rise on the same clock edge -> state LOAD, bitIndex = 0, no shift.
- Async reset during SHIFT at bitIndex = 5 -> outputs return to reset values in the same cycle. A following full frame reads correctly.

Source files
------------

// File: rtl/nes_controller_emulator.sv
// nes_controller_emulator
//   Responder end of the NES controller serial link. Emulates a standard
//   8-button pad (4021-style shift register) so a console or the NES
//   controller reader can poll board-generated button states.
//
// Ports
//   clock        in   50 MHz system clock, rising-edge active
//   reset_n      in   asynchronous active-low reset
//   latchOrange  in   latch from the polling side, active-high, async
//   clockRed     in   serial pulse clock from the polling side, idle low, async
//   a..right     in   button levels, 1 = pressed
//   dataYellow   out  serial data, 0 = pressed / 1 = released
//   bitIndex     out  index of the bit currently on dataYellow (0..8)
//   frameDone    out  one-cycle pulse when the 8th bit has been shifted past
module nes_controller_emulator #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       latchOrange,
  input  logic       clockRed,
  input  logic       a,
  input  logic       b,
  input  logic       select,
  input  logic       start,
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  output logic       dataYellow,
  output logic [3:0] bitIndex,
  output logic       frameDone
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [7:0]             sr_q, sr_d;
  logic [3:0]             idx_q, idx_d;
  logic                   done_q, done_d;

  logic [SYNC_STAGES-1:0] latch_sync_q;
  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic                   latch_hist_q;
  logic                   clk_hist_q;

  logic                   latch_lvl;
  logic                   clk_lvl;
  logic                   latch_rise;
  logic                   clk_rise;
  logic [7:0]             buttons;

  // Synchronizer chains plus one history flop each for edge detection.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      latch_sync_q <= '0;
      clk_sync_q   <= '0;
      latch_hist_q <= 1'b0;
      clk_hist_q   <= 1'b0;
    end else begin
      latch_sync_q <= {latch_sync_q[SYNC_STAGES-2:0], latchOrange};
      clk_sync_q   <= {clk_sync_q[SYNC_STAGES-2:0], clockRed};
      latch_hist_q <= latch_sync_q[SYNC_STAGES-1];
      clk_hist_q   <= clk_sync_q[SYNC_STAGES-1];
    end
  end

  assign latch_lvl  = latch_sync_q[SYNC_STAGES-1];
  assign clk_lvl    = clk_sync_q[SYNC_STAGES-1];
  assign latch_rise = latch_lvl & ~latch_hist_q;
  assign clk_rise   = clk_lvl & ~clk_hist_q;

  // Standard NES order, A shifted out first.
  assign buttons = {right, left, down, up, start, select, b, a};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    // A latch rise restarts from any state and swallows a coincident clock edge.
    if (latch_rise) begin
      state_d = ST_LOAD;
      sr_d    = buttons;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          sr_d  = '0;
          idx_d = '0;
        end
        ST_LOAD: begin
          idx_d = '0;
          // Parallel-load tracks the buttons while latch is high; freezes on fall.
          if (latch_lvl) begin
            sr_d = buttons;
          end else begin
            state_d = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (clk_rise) begin
            sr_d  = {1'b0, sr_q[7:1]};
            idx_d = idx_q + 4'd1;
            if (idx_q == 4'd7) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
          end
        end
        ST_DONE: begin
          idx_d = 4'd8;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Drained pad reads as all-ones (pressed) to the console, hence 0 in DONE.
  always_comb begin
    dataYellow = 1'b1;
    unique case (state_q)
      ST_IDLE:  dataYellow = 1'b1;
      ST_LOAD:  dataYellow = ~sr_q[0];
      ST_SHIFT: dataYellow = ~sr_q[0];
      ST_DONE:  dataYellow = 1'b0;
      default:  dataYellow = 1'b1;
    endcase
  end

  assign bitIndex  = idx_q;
  assign frameDone = done_q;

endmodule

// File: tb/tb_nes_controller_emulator.sv
// tb_nes_controller_emulator
//   Directed bench for nes_controller_emulator: reset behaviour, full frame,
//   over-clocking, mid-frame relatch, latch/clock collision and async reset
//   during shift.
module tb_nes_controller_emulator;

  logic       clock;
  logic       reset_n;
  logic       latchOrange;
  logic       clockRed;
  logic       a, b, select, start, up, down, left, right;
  logic       dataYellow;
  logic [3:0] bitIndex;
  logic       frameDone;

  int vectors    = 0;
  int miscompares = 0;
  int fd_count   = 0;
  int fd_mark;

  // a=1, start=1, right=1 -> samples 0,1,1,0,1,1,1,0 (bit k = sample k)
  logic [7:0] exp_seq;

  nes_controller_emulator #(.SYNC_STAGES(2)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .latchOrange(latchOrange),
    .clockRed   (clockRed),
    .a          (a),
    .b          (b),
    .select     (select),
    .start      (start),
    .up         (up),
    .down       (down),
    .left       (left),
    .right      (right),
    .dataYellow (dataYellow),
    .bitIndex   (bitIndex),
    .frameDone  (frameDone)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  // Counts cycles with frameDone high.
  always @(posedge clock) begin
    if (frameDone === 1'b1) fd_count <= fd_count + 1;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_buttons(input logic [7:0] v);
    {right, left, down, up, start, select, b, a} = v;
  endtask

  task automatic pulse();
    clockRed = 1'b1;
    tick(10);
    clockRed = 1'b0;
    tick(10);
  endtask

  task automatic do_latch(input int n);
    latchOrange = 1'b1;
    tick(n);
    latchOrange = 1'b0;
    tick(5);
  endtask

  // Full frame with a, start, right pressed, checked bit by bit.
  task automatic full_frame(input string tag);
    set_buttons(8'b1000_1001);
    fd_mark = fd_count;
    latchOrange = 1'b1;
    tick(6);
    check({tag, "_load_data"}, {7'd0, dataYellow}, 8'd0);
    check({tag, "_load_idx"}, {4'd0, bitIndex}, 8'd0);
    tick(6);
    latchOrange = 1'b0;
    tick(5);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("%s_bit%0d", tag, k), {7'd0, dataYellow}, {7'd0, exp_seq[k]});
      check($sformatf("%s_idx%0d", tag, k), {4'd0, bitIndex}, k[7:0]);
      pulse();
    end
    check({tag, "_done_idx"}, {4'd0, bitIndex}, 8'd8);
    check({tag, "_done_data"}, {7'd0, dataYellow}, 8'd0);
    check({tag, "_fd_once"}, 8'(fd_count - fd_mark), 8'd1);
  endtask

  initial begin
    exp_seq     = 8'b0111_0110;
    reset_n     = 1'b0;
    latchOrange = 1'b0;
    clockRed    = 1'b0;
    set_buttons(8'hFF);

    // Reset held: pins toggling must not move the outputs.
    tick(2);
    for (int i = 0; i < 4; i++) begin
      latchOrange = ~latchOrange;
      clockRed    = ~clockRed;
      tick(4);
    end
    latchOrange = 1'b0;
    clockRed    = 1'b0;
    check("rst_data", {7'd0, dataYellow}, 8'd1);
    check("rst_idx", {4'd0, bitIndex}, 8'd0);
    check("rst_fd", {7'd0, frameDone}, 8'd0);

    // Release: nothing happens until a latch rise, even with a clock pulse.
    reset_n = 1'b1;
    tick(5);
    pulse();
    check("idle_data", {7'd0, dataYellow}, 8'd1);
    check("idle_idx", {4'd0, bitIndex}, 8'd0);
    check("idle_fd", 8'(fd_count), 8'd0);

    // Full frame.
    full_frame("frame1");

    // Over-clocking after the frame.
    fd_mark = fd_count;
    for (int k = 0; k < 4; k++) begin
      pulse();
      check($sformatf("over%0d_data", k), {7'd0, dataYellow}, 8'd0);
      check($sformatf("over%0d_idx", k), {4'd0, bitIndex}, 8'd8);
    end
    check("over_fd", 8'(fd_count - fd_mark), 8'd0);

    // Relatch mid-frame with only B pressed.
    set_buttons(8'b1000_1001);
    do_latch(12);
    fd_mark = fd_count;
    for (int k = 0; k < 3; k++) pulse();
    check("pre_relatch_idx", {4'd0, bitIndex}, 8'd3);
    set_buttons(8'b0000_0010);
    do_latch(12);
    check("relatch_idx", {4'd0, bitIndex}, 8'd0);
    check("relatch_bit0", {7'd0, dataYellow}, 8'd1);
    pulse();
    check("relatch_bit1", {7'd0, dataYellow}, 8'd0);
    check("relatch_idx1", {4'd0, bitIndex}, 8'd1);
    check("relatch_fd", 8'(fd_count - fd_mark), 8'd0);

    // Collision: latch and clock rise together while shifting.
    latchOrange = 1'b1;
    clockRed    = 1'b1;
    tick(6);
    check("coll_idx", {4'd0, bitIndex}, 8'd0);
    check("coll_data", {7'd0, dataYellow}, 8'd1);
    latchOrange = 1'b0;
    clockRed    = 1'b0;
    tick(5);
    check("coll_shift_idx", {4'd0, bitIndex}, 8'd0);
    check("coll_shift_bit0", {7'd0, dataYellow}, 8'd1);
    pulse();
    check("coll_shift_bit1", {7'd0, dataYellow}, 8'd0);
    check("coll_shift_idx1", {4'd0, bitIndex}, 8'd1);

    // Async reset in the middle of a frame at bitIndex = 5.
    set_buttons(8'b1000_1001);
    do_latch(12);
    for (int k = 0; k < 5; k++) pulse();
    check("mid_idx5", {4'd0, bitIndex}, 8'd5);
    #4;
    reset_n = 1'b0;
    #1;
    check("async_rst_data", {7'd0, dataYellow}, 8'd1);
    check("async_rst_idx", {4'd0, bitIndex}, 8'd0);
    check("async_rst_fd", {7'd0, frameDone}, 8'd0);
    tick(3);
    reset_n = 1'b1;
    tick(5);
    check("post_rst_idx", {4'd0, bitIndex}, 8'd0);

    full_frame("frame2");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
